// File: rtl/text_fetch_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | text_pkg: text-mode geometry, VRAM address types, sideband record   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package text_pkg;

  localparam int H_CHARS        = 80;
  localparam int V_CHARS        = 30;
  localparam int CHAR_W         = 8;
  localparam int CHAR_H         = 16;
  localparam int CHARS_PER_WORD = 2;
  localparam int VRAM_WORDS     = H_CHARS * V_CHARS / CHARS_PER_WORD;
  localparam int ADDR_W         = 11;

  typedef logic [9:0]        pix_coord_t;
  typedef logic [ADDR_W-1:0] vram_addr_t;

  typedef struct packed {
    pix_coord_t DrawX;
    pix_coord_t DrawY;
    logic       hsync;
    logic       vsync;
    logic       vde;
    logic       en;
  } sideband_t;

  // Syncs are active low, so the idle record keeps them high.
  localparam sideband_t SB_IDLE = '{
    DrawX: '0, DrawY: '0, hsync: 1'b1, vsync: 1'b1, vde: 1'b0, en: 1'b0
  };

endpackage
`default_nettype wire

// File: rtl/text_fetch_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | text_fetch_pipe_if: VRAM port-B read bus (address, enable, data)    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface text_fetch_pipe_if #(
  parameter int ADDR_W = 11
);

  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic [31:0]       bram_data;

  modport master (
    output bram_addr,
    output bram_en,
    input  bram_data
  );

  modport slave (
    input  bram_addr,
    input  bram_en,
    output bram_data
  );

endinterface
`default_nettype wire

// File: rtl/text_fetch_pipe_sideband_delay.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sideband_delay: depth-N shift register of sideband_t records        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sideband_delay
  import text_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  sideband_t  i_sb,
  output pix_coord_t o_drawx,
  output pix_coord_t o_drawy,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_vde,
  output logic       o_tap_en,
  output logic       o_tap_vsync
);

  sideband_t r_stage [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_stage[i] <= SB_IDLE;
      end
    end else begin
      r_stage[0] <= i_sb;
      for (int i = 1; i < N; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_drawx = r_stage[N-1].DrawX;
  assign o_drawy = r_stage[N-1].DrawY;
  assign o_hsync = r_stage[N-1].hsync;
  assign o_vsync = r_stage[N-1].vsync;
  assign o_vde   = r_stage[N-1].vde;

  // The stage before the output lines up with the BRAM data arriving at the final register.
  assign o_tap_en    = r_stage[N-2].en;
  assign o_tap_vsync = r_stage[N-2].vsync;

endmodule
`default_nettype wire

// File: rtl/text_fetch_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | text_fetch_pipe: VRAM word fetch aligned with delayed VGA timing    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module text_fetch_pipe #(
  parameter int H_CHARS        = text_pkg::H_CHARS,
  parameter int V_CHARS        = text_pkg::V_CHARS,
  parameter int CHAR_W         = text_pkg::CHAR_W,
  parameter int CHAR_H         = text_pkg::CHAR_H,
  parameter int CHARS_PER_WORD = text_pkg::CHARS_PER_WORD,
  parameter int RD_LAT         = 2,
  parameter int ADDR_W         = text_pkg::ADDR_W
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        vde_in,
  text_fetch_pipe_if.master bram,
  output logic [31:0] bram_data_out,
  output logic [9:0]  DrawX_out,
  output logic [9:0]  DrawY_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        vde_out,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  import text_pkg::sideband_t;

  localparam int PIPE          = RD_LAT + 2;
  localparam int WORDS_PER_ROW = H_CHARS / CHARS_PER_WORD;
  localparam int X_SH          = $clog2(CHAR_W * CHARS_PER_WORD);
  localparam int Y_SH          = $clog2(CHAR_H);
  localparam int X_LIM         = H_CHARS * CHAR_W;
  localparam int Y_LIM         = V_CHARS * CHAR_H;

  logic [11:0]       w_row;
  logic [11:0]       w_col;
  logic [11:0]       w_addr12;
  logic              w_in_range;
  sideband_t         w_sb_in;
  logic              w_tap_en;
  logic              w_tap_vsync;
  logic              w_vs_fall;

  logic [ADDR_W-1:0] r_addr;
  logic              r_en;
  logic [31:0]       r_data;
  logic              r_frame_start;
  logic [7:0]        r_frame_count;

  // Constant multiply by words-per-row; synthesis reduces it to shift-add.
  assign w_row    = 12'(DrawY) >> Y_SH;
  assign w_col    = 12'(DrawX) >> X_SH;
  assign w_addr12 = w_row * 12'(WORDS_PER_ROW) + w_col;

  assign w_in_range = vde_in && (32'(DrawX) < X_LIM) && (32'(DrawY) < Y_LIM);

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_addr <= '0;
      r_en   <= 1'b0;
    end else begin
      r_en <= w_in_range;
      if (w_in_range) begin
        r_addr <= w_addr12[ADDR_W-1:0];
      end
    end
  end

  assign bram.bram_addr = r_addr;
  assign bram.bram_en   = r_en;

  assign w_sb_in = '{
    DrawX: DrawX, DrawY: DrawY, hsync: hsync_in,
    vsync: vsync_in, vde: vde_in, en: w_in_range
  };

  sideband_delay #(
    .N (PIPE)
  ) u_sideband_delay (
    .clk         (pixel_clk),
    .rst         (reset),
    .i_sb        (w_sb_in),
    .o_drawx     (DrawX_out),
    .o_drawy     (DrawY_out),
    .o_hsync     (hsync_out),
    .o_vsync     (vsync_out),
    .o_vde       (vde_out),
    .o_tap_en    (w_tap_en),
    .o_tap_vsync (w_tap_vsync)
  );

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_tap_en) begin
      r_data <= bram.bram_data;
    end
  end

  assign bram_data_out = r_data;

  // vsync_out is high now and the tap shows it goes low on this edge.
  assign w_vs_fall = vsync_out & ~w_tap_vsync;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_start <= w_vs_fall;
      if (w_vs_fall) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire
